// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states and
// the active-low hex-to-segment table.
package seg_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // {g,f,e,d,c,b,a}, active-low, indexed by nibble value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the digit datapath (master) and the scan controller (slave).
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output enable, digits, dp_in, blank_mask,
        input  an, seg, dp, digit_idx, frame_done
    );

    modport slave (
        input  enable, digits, dp_in, blank_mask,
        output an, seg, dp, digit_idx, frame_done
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS seven-segment digits: one anode per slot,
// all-dark blank gap between slots, inputs snapshotted once per frame.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [DIV_W-1:0] PRESC_MAX = '1;
    localparam logic [DIV_W-1:0] PRESC_PRE = PRESC_MAX - DIV_W'(1);

    state_e                  state_q;
    logic [DIV_W-1:0]        presc_q;
    logic [CNT_W-1:0]        blank_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [NUM_DIGITS-1:0]   snap_blank_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    frame_done_q;

    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            dec_seg;
    logic                  last_digit;
    logic [IDX_W-1:0]      idx_next;

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = snap_digits_q[4*i +: 4];
                cur_dp     = snap_dp_q[i];
                cur_blank  = snap_blank_q[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign idx_next   = last_digit ? '0 : idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            presc_q       <= '0;
            blank_q       <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else if (!bus.enable) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            blank_q      <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    state_q       <= StBlank;
                    idx_q         <= '0;
                    blank_q       <= '0;
                    snap_digits_q <= bus.digits;
                    snap_dp_q     <= bus.dp_in;
                    snap_blank_q  <= bus.blank_mask;
                end
                StBlank: begin
                    if (blank_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_q <= StShow;
                        blank_q <= '0;
                        presc_q <= '0;
                        // A masked digit still consumes its slot, just stays dark
                        if (!cur_blank) begin
                            an_q  <= an_sel;
                            seg_q <= dec_seg;
                            dp_q  <= ~cur_dp;
                        end
                    end else begin
                        blank_q <= blank_q + CNT_W'(1);
                    end
                end
                StShow: begin
                    presc_q <= presc_q + DIV_W'(1);
                    if (presc_q == PRESC_MAX) begin
                        state_q <= StBlank;
                        idx_q   <= idx_next;
                        an_q    <= '1;
                        seg_q   <= SEG_OFF;
                        dp_q    <= 1'b1;
                        if (last_digit) begin
                            snap_digits_q <= bus.digits;
                            snap_dp_q     <= bus.dp_in;
                            snap_blank_q  <= bus.blank_mask;
                        end
                    end else if (last_digit && presc_q == PRESC_PRE) begin
                        // Registered one cycle early so the pulse covers the final SHOW cycle
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based frame model predicts every cycle's
// outputs, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int DIV_W      = 3;
    localparam int BLANK      = 2;
    localparam int SLOT       = BLANK + (1 << DIV_W);
    localparam int FRAME      = NUM_DIGITS * SLOT;

    localparam logic [6:0] SEG_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       fd;
    } obs_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    obs_t exp_q[$];

    seg_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV_W        (DIV_W),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position inside the frame is derived from elapsed cycles.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    int         m_slot;
    int         m_pos;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;

    always @(posedge clk) begin
        obs_t e;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.idx = 2'd0;
        e.fd  = 1'b0;
        if (!reset || !bus.enable) begin
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_t      = 0;
                m_digits = bus.digits;
                m_dp     = bus.dp_in;
                m_blank  = bus.blank_mask;
            end else begin
                m_t = m_t + 1;
                if (m_t % FRAME == 0) begin
                    m_digits = bus.digits;
                    m_dp     = bus.dp_in;
                    m_blank  = bus.blank_mask;
                end
            end
            m_slot = (m_t % FRAME) / SLOT;
            m_pos  = (m_t % FRAME) % SLOT;
            e.idx  = 2'(m_slot);
            if (m_pos >= BLANK && !m_blank[m_slot]) begin
                e.an  = ~(4'b0001 << m_slot);
                e.seg = SEG_REF[m_digits[4*m_slot +: 4]];
                e.dp  = ~m_dp[m_slot];
            end
            e.fd = (m_slot == NUM_DIGITS - 1) && (m_pos == SLOT - 1);
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        a = {bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_done};
        checks++;
        if ($countones(~a.an) > 1) begin
            errors++;
            $display("FAIL one_anode t=%0t an=%b has more than one low bit", $time, a.an);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_obs t=%0t got an=%h seg=%h dp=%b idx=%0d fd=%b want an=%h seg=%h dp=%b idx=%0d fd=%b",
                         $time, a.an, a.seg, a.dp, a.idx, a.fd, e.an, e.seg, e.dp, e.idx, e.fd);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        while (bus.an !== target && n < 200) begin
            step(1);
            n++;
        end
        if (bus.an !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_an timeout an=%h required %h", bus.an, target);
        end
    endtask

    task automatic check_dark(input string name);
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 ||
            bus.digit_idx !== 2'd0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s got an=%h seg=%h dp=%b idx=%0d fd=%b want an=f seg=7f dp=1 idx=0 fd=0",
                     name, bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_done);
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.enable     = 1'b1;
        bus.digits     = 16'h3210;
        bus.dp_in      = 4'h0;
        bus.blank_mask = 4'h0;

        // Reset held with enable high
        step(3);
        check_dark("reset_state");
        reset = 1'b1;

        // Two full frames of 0,1,2,3
        step(2 * FRAME);

        // Change digits while digit 1 is on screen
        wait_an(4'hD);
        bus.digits = 16'hFFFF;
        step(2 * FRAME);

        // Masked digit 2, decimal point on digit 0
        bus.digits     = 16'($urandom());
        bus.blank_mask = 4'b0100;
        bus.dp_in      = 4'b0001;
        step(2 * FRAME);

        // Disable during digit 2 SHOW, then restart
        bus.blank_mask = 4'b0000;
        step(FRAME);
        wait_an(4'hB);
        bus.enable = 1'b0;
        step(3);
        bus.enable = 1'b1;
        step(FRAME);

        // Asynchronous reset between edges while a digit is lit
        wait_an(4'hE);
        #5;
        reset = 1'b0;
        #1;
        check_dark("async_reset");
        step(2);
        reset = 1'b1;
        step(FRAME + 10);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.digits = 16'($urandom());
            if ($urandom_range(0, 7) == 0) bus.dp_in = 4'($urandom());
            if ($urandom_range(0, 15) == 0) bus.blank_mask = 4'($urandom());
            if ($urandom_range(0, 99) < 2) begin
                bus.enable = 1'b0;
                step($urandom_range(1, 3));
                bus.enable = 1'b1;
            end
            step(1);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
